// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache fill FSMs.
// Grants are locked per fill; returning read words are steered by an owner tag pipe.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              err
);

  localparam int unsigned Head = MEM_LAT - 1;

  typedef enum logic [1:0] {StIdle, StOwnI, StOwnD} state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;  // 1: D-cache was the most recent owner
  logic   err_q, err_d;

  // Per in-flight read: valid bit and owner (1 = D-cache)
  logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0] tag_own_q, tag_own_d;

  logic own_i, own_d;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    unique case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
          state_d = last_d_q ? StOwnI : StOwnD;
        end else if (d_req) begin
          state_d = StOwnD;
        end else if (i_req) begin
          state_d = StOwnI;
        end
      end
      StOwnI: begin
        if (!i_req) begin
          state_d = d_req ? StOwnD : StIdle;
        end
      end
      StOwnD: begin
        if (!d_req) begin
          state_d = i_req ? StOwnI : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StOwnI) begin
      last_d_d = 1'b0;
    end else if (state_d == StOwnD) begin
      last_d_d = 1'b1;
    end
  end

  assign own_i   = (state_q == StOwnI);
  assign own_d   = (state_q == StOwnD);
  assign i_grant = own_i;
  assign d_grant = own_d;

  assign mem_en    = (own_i & i_req) | (own_d & d_req);
  assign mem_wr    = own_d & d_req & d_wr;
  assign mem_addr  = own_d ? d_addr : (own_i ? i_addr : '0);
  // Data passthroughs are forced low while reset is asserted
  assign mem_wdata = rst ? d_wdata : '0;
  assign rdata     = rst ? mem_rdata : '0;

  always_comb begin
    tag_vld_d = '0;
    tag_own_d = '0;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
    tag_vld_d[0] = mem_en & ~mem_wr;
    tag_own_d[0] = own_d;
  end

  assign i_data_valid = mem_rdata_valid & tag_vld_q[Head] & ~tag_own_q[Head];
  assign d_data_valid = mem_rdata_valid & tag_vld_q[Head] & tag_own_q[Head];

  assign err_d = err_q | (mem_rdata_valid & ~tag_vld_q[Head]);
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// compared against a cycle-indexed reference model of grants and read returns.
module tb_mem_arbiter;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, mem_rdata_valid = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          i_grant, i_data_valid, d_grant, d_data_valid, mem_en, mem_wr, err;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_data_valid(d_data_valid), .rdata(rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner 0 none / 1 I / 2 D; last 1 I / 2 D; returns keyed by cycle
  int            own, last, cyc;
  int            due_own[int];
  logic [DW-1:0] due_dat[int];
  bit            err_m, drop_en, spur;
  logic          exp_ig, exp_dg, exp_en, exp_wr, exp_idv, exp_ddv;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_rdata;

  // Called just after a rising edge: derive expectations and drive the memory side
  task automatic prep();
    exp_ig   = (own == 1);
    exp_dg   = (own == 2);
    exp_en   = (own == 1 && i_req) || (own == 2 && d_req);
    exp_wr   = (own == 2 && d_req && d_wr);
    exp_addr = (own == 2) ? d_addr : i_addr;
    exp_idv  = 1'b0;
    exp_ddv  = 1'b0;
    if (due_own.exists(cyc)) begin
      mem_rdata       = due_dat[cyc];
      mem_rdata_valid = !(drop_en && $urandom_range(7) == 0);
      exp_idv         = mem_rdata_valid && due_own[cyc] == 1;
      exp_ddv         = mem_rdata_valid && due_own[cyc] == 2;
    end else begin
      mem_rdata       = DW'($urandom);
      mem_rdata_valid = spur;
    end
    exp_rdata = mem_rdata;
    #1;
  endtask

  task automatic adv();
    if (exp_en && !exp_wr) begin
      due_own[cyc + int'(LAT)] = own;
      due_dat[cyc + int'(LAT)] = DW'($urandom);
    end
    if (due_own.exists(cyc)) begin
      due_own.delete(cyc);
      due_dat.delete(cyc);
    end else if (mem_rdata_valid) begin
      err_m = 1'b1;
    end
    case (own)
      0: begin
        if (i_req && d_req) own = (last == 1) ? 2 : 1;
        else if (d_req) own = 2;
        else if (i_req) own = 1;
      end
      1: if (!i_req) own = d_req ? 2 : 0;
      default: if (!d_req) own = i_req ? 1 : 0;
    endcase
    if (own != 0) last = own;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    mem_rdata_valid = 1'b0;
    spur = 1'b0;
    due_own.delete();
    due_dat.delete();
    own = 0;
    last = 1;
    err_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1; i_addr = 16'h1111; d_addr = 16'h2222;
    d_wdata = 16'h3333; mem_rdata = 16'h4444; mem_rdata_valid = 1'b1;
    #20;
    checks++; if ({i_grant, d_grant, mem_en, mem_wr} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {i_grant, d_grant, mem_en, mem_wr});
    end
    checks++; if ({i_data_valid, d_data_valid, err} !== 3'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {i_data_valid, d_data_valid, err});
    end
    checks++; if (mem_addr !== '0) begin
      errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr);
    end
    checks++; if (rdata !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0/0", rdata, mem_wdata);
    end
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    apply_reset();
  endtask

  task automatic test_i_alone();
    int n_i = 0, n_d = 0;
    apply_reset();
    drop_en = 1'b0;
    for (int c = 0; c < 9 + int'(LAT) + 3; c++) begin
      i_req = (c < 9);
      i_addr = 16'h0100 + 16'(c);
      prep();
      if (c == 0) begin
        checks++; if (i_grant !== 1'b0) begin
          errors++; $display("FAIL ialone_grant0 got=%b exp=0", i_grant);
        end
      end
      if (c == 1) begin
        checks++; if (i_grant !== 1'b1 || mem_en !== 1'b1) begin
          errors++; $display("FAIL ialone_grant1 got=%b%b exp=11", i_grant, mem_en);
        end
        checks++; if (mem_addr !== 16'h0101) begin
          errors++; $display("FAIL ialone_addr got=%h exp=0101", mem_addr);
        end
      end
      if (c == 1 + int'(LAT)) begin
        checks++; if (i_data_valid !== 1'b1) begin
          errors++; $display("FAIL ialone_first_return got=%b exp=1", i_data_valid);
        end
      end
      if (i_data_valid === 1'b1) n_i++;
      if (d_data_valid === 1'b1) n_d++;
      adv();
    end
    checks++; if (n_i != 8 || n_d != 0) begin
      errors++; $display("FAIL ialone_count got=%0d/%0d exp=8/0", n_i, n_d);
    end
  endtask

  task automatic test_both_rr();
    int n_i = 0, n_d = 0, bad = 0;
    apply_reset();
    drop_en = 1'b0;
    d_wr = 1'b0;
    for (int c = 0; c < 25; c++) begin
      i_req = (c < 18);
      d_req = (c < 9);
      i_addr = 16'h0200 + 16'(c);
      d_addr = 16'h0300 + 16'(c);
      prep();
      if (c == 1) begin
        checks++; if (d_grant !== 1'b1 || i_grant !== 1'b0) begin
          errors++; $display("FAIL rr_first got=d%b i%b exp=d1 i0", d_grant, i_grant);
        end
      end
      if (c == 10) begin
        checks++; if (i_grant !== 1'b1 || d_grant !== 1'b0) begin
          errors++; $display("FAIL rr_switch got=i%b d%b exp=i1 d0", i_grant, d_grant);
        end
      end
      if (d_data_valid === 1'b1) begin
        n_d++;
        if (c < 5 || c > 12) bad++;
      end
      if (i_data_valid === 1'b1) begin
        n_i++;
        if (c < 14 || c > 21) bad++;
      end
      adv();
    end
    checks++; if (n_d != 8 || n_i != 8 || bad != 0) begin
      errors++; $display("FAIL rr_steer got=d%0d i%0d bad%0d exp=d8 i8 bad0", n_d, n_i, bad);
    end
  endtask

  task automatic test_trailing();
    int n_d = 0, bad_i = 0;
    apply_reset();
    drop_en = 1'b0;
    d_wr = 1'b0;
    for (int c = 0; c < 14; c++) begin
      d_req = (c < 4);
      i_req = (c >= 2 && c < 9);
      i_addr = 16'h0400 + 16'(c);
      d_addr = 16'h0500 + 16'(c);
      prep();
      if (c == 5) begin
        checks++; if (i_grant !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 16'h0405) begin
          errors++;
          $display("FAIL trail_issue got=%b%b %h exp=11 0405", i_grant, mem_en, mem_addr);
        end
      end
      if (d_data_valid === 1'b1) n_d++;
      if (i_data_valid === 1'b1 && c < 9) bad_i++;
      adv();
    end
    checks++; if (n_d != 3 || bad_i != 0) begin
      errors++; $display("FAIL trail_steer got=d%0d badi%0d exp=d3 badi0", n_d, bad_i);
    end
  endtask

  task automatic test_write();
    int n_dv = 0;
    apply_reset();
    d_wr = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF; i_req = 1'b0;
    for (int c = 0; c < int'(LAT) + 4; c++) begin
      d_req = (c < 2);
      spur = (c == 1 + int'(LAT));
      prep();
      if (c == 1) begin
        checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b1) begin
          errors++; $display("FAIL write_strobe got=%b%b exp=11", mem_en, mem_wr);
        end
        checks++; if (mem_addr !== 16'h1234 || mem_wdata !== 16'hBEEF) begin
          errors++; $display("FAIL write_bus got=%h/%h exp=1234/beef", mem_addr, mem_wdata);
        end
      end
      if (i_data_valid === 1'b1 || d_data_valid === 1'b1) n_dv++;
      adv();
    end
    spur = 1'b0;
    d_wr = 1'b0;
    checks++; if (n_dv != 0) begin
      errors++; $display("FAIL write_no_tag got=%0d exp=0", n_dv);
    end
    checks++; if (err !== 1'b1) begin
      errors++; $display("FAIL write_untagged_err got=%b exp=1", err);
    end
  endtask

  task automatic test_err();
    apply_reset();
    i_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      spur = (c == 1);
      prep();
      if (c == 1) begin
        checks++; if (err !== 1'b0) begin
          errors++; $display("FAIL err_pre got=%b exp=0", err);
        end
      end
      if (c == 2 || c == 5) begin
        checks++; if (err !== 1'b1) begin
          errors++; $display("FAIL err_sticky c=%0d got=%b exp=1", c, err);
        end
      end
      adv();
    end
    spur = 1'b0;
    mem_rdata_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear got=%b exp=0", err);
    end
    apply_reset();
  endtask

  task automatic test_async_reset();
    apply_reset();
    drop_en = 1'b0;
    i_req = 1'b1; d_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_addr = 16'h0600 + 16'(c);
      prep();
      adv();
    end
    d_wdata = 16'hA5A5; mem_rdata = 16'hFFFF; mem_rdata_valid = 1'b1;
    rst = 1'b0;
    #1;
    checks++; if ({i_grant, mem_en, i_data_valid, err} !== 4'b0) begin
      errors++;
      $display("FAIL async_ctrl got=%b exp=0000", {i_grant, mem_en, i_data_valid, err});
    end
    checks++; if (mem_addr !== '0 || rdata !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL async_data got=%h/%h/%h exp=0", mem_addr, rdata, mem_wdata);
    end
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      prep();
      checks++; if (i_grant !== (c == 1)) begin
        errors++; $display("FAIL async_regrant c=%0d got=%b exp=%b", c, i_grant, c == 1);
      end
      adv();
    end
    i_req = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    drop_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(9) == 0) i_req = ~i_req;
      if ($urandom_range(9) == 0) d_req = ~d_req;
      d_wr = ($urandom_range(3) == 0);
      i_addr = AW'($urandom);
      d_addr = AW'($urandom);
      d_wdata = DW'($urandom);
      prep();
      checks++; if (i_grant !== exp_ig || d_grant !== exp_dg) begin
        errors++; $display("FAIL rand_grant cyc=%0d got=%b%b exp=%b%b", cyc, i_grant, d_grant,
                           exp_ig, exp_dg);
      end
      checks++; if (mem_en !== exp_en || mem_wr !== exp_wr) begin
        errors++; $display("FAIL rand_issue cyc=%0d got=%b%b exp=%b%b", cyc, mem_en, mem_wr,
                           exp_en, exp_wr);
      end
      if (exp_en) begin
        checks++; if (mem_addr !== exp_addr) begin
          errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_addr);
        end
      end
      checks++; if (mem_wdata !== d_wdata || rdata !== exp_rdata) begin
        errors++; $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", cyc, mem_wdata, rdata,
                           d_wdata, exp_rdata);
      end
      checks++; if (i_data_valid !== exp_idv || d_data_valid !== exp_ddv) begin
        errors++; $display("FAIL rand_steer cyc=%0d got=%b%b exp=%b%b", cyc, i_data_valid,
                           d_data_valid, exp_idv, exp_ddv);
      end
      checks++; if (err !== err_m) begin
        errors++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, err, err_m);
      end
      adv();
    end
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; drop_en = 1'b0;
  endtask

  initial begin
    own = 0; last = 1; cyc = 0; err_m = 1'b0; drop_en = 1'b0; spur = 1'b0;
    test_reset();
    test_i_alone();
    test_both_rr();
    test_trailing();
    test_write();
    test_err();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
